// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its datapath muxes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Unified-memory request/ready handshake between controller and memory.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_ready;
    logic MemWrite;
    logic AdrSrc;

    modport master (output mem_req, output MemWrite, output AdrSrc, input mem_ready);
    modport slave  (input mem_req, input MemWrite, input AdrSrc, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: fetch, decode, execute,
// memory and writeback, with a req/ready stall on every memory access.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [6:0]                      opcode,
    multicycle_controller_if.master         mem,
    output logic                            IRWrite,
    output logic                            PCUpdate,
    output logic                            Branch,
    output logic                            RegWrite,
    output logic [1:0]                      ALUSrcA,
    output logic [1:0]                      ALUSrcB,
    output logic [1:0]                      ALUOp,
    output logic [1:0]                      ResultSrc,
    output logic                            illegal,
    output logic                            retire,
    output logic [3:0]                      state_dbg
);

    state_t r_state;
    state_t w_next_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = mem.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_R:              w_next_state = S_EXECR;
                    OP_IALU:           w_next_state = S_EXECI;
                    OP_BRANCH:         w_next_state = S_BEQ;
                    OP_JAL:            w_next_state = S_JAL;
                    default:           w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = mem.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: w_next_state = mem.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Outputs are gated by reset so a pending request drops in the same cycle.
    always_comb begin
        mem.mem_req  = 1'b0;
        mem.MemWrite = 1'b0;
        mem.AdrSrc   = 1'b0;
        IRWrite      = 1'b0;
        PCUpdate     = 1'b0;
        Branch       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        ALUOp        = ALUOP_ADD;
        ResultSrc    = RES_ALUOUT;
        illegal      = 1'b0;
        retire       = 1'b0;
        state_dbg    = S_FETCH;
        if (!reset) begin
            state_dbg = r_state;
            case (r_state)
                S_FETCH: begin
                    mem.mem_req = 1'b1;
                    ALUSrcB     = SRCB_FOUR;
                    ResultSrc   = RES_ALU;
                    IRWrite     = mem.mem_ready;
                    PCUpdate    = mem.mem_ready;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    case (opcode)
                        OP_LOAD, OP_STORE, OP_R, OP_IALU, OP_BRANCH, OP_JAL: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem.mem_req = 1'b1;
                    mem.AdrSrc  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem.mem_req  = 1'b1;
                    mem.MemWrite = 1'b1;
                    mem.AdrSrc   = 1'b1;
                    retire       = mem.mem_ready;
                end
                S_MEMWB: begin
                    ResultSrc = RES_MEM;
                    RegWrite  = 1'b1;
                    retire    = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    ALUOp   = ALUOP_FUNC;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNC;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    ALUOp   = ALUOP_SUB;
                    Branch  = 1'b1;
                    retire  = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA  = SRCA_OLDPC;
                    ALUSrcB  = SRCB_FOUR;
                    PCUpdate = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multi-cycle RV32I core. Each instruction is stepped through fetch, decode, execute, memory and writeback, and the controller drives per-state mux selects and write enables into the shared datapath (PC, IR, ALU, register file, unified memory). Memory accesses use a req/ready handshake so variable-latency memory stalls the FSM cleanly. Covers R-type, I-type ALU, load, store, beq and jal.

## Interface
- `clk` input 1: rising-edge clock
- `reset` input 1: synchronous, active-high
- `opcode` input 7: IR[6:0] (valid from DECODE onward)
- `mem_ready` input 1: memory completes the current request this cycle
- `mem_req` output 1: memory request active
- `MemWrite` output 1: request is a write
- `AdrSrc` output 1: 0 = PC, 1 = ALUOut
- `IRWrite` output 1: latch IR and OldPC
- `PCUpdate` output 1: unconditional PC write
- `Branch` output 1: PC write if ALU zero
- `RegWrite` output 1: register file write
- `ALUSrcA` output 2: 00 PC, 01 OldPC, 10 rs1
- `ALUSrcB` output 2: 00 rs2, 01 imm, 10 constant 4
- `ALUOp` output 2: 00 add, 01 sub/compare, 10 funct-decoded
- `ResultSrc` output 2: 00 ALUOut, 01 memory data, 10 ALU result
- `illegal` output 1: one-cycle pulse on unsupported opcode
- `retire` output 1: one-cycle pulse in the final state of each instruction
- `state_dbg` output 4: current state encoding

## Operation
- States and transitions:
  - FETCH → DECODE when `mem_ready`; otherwise FETCH.
  - DECODE by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → FETCH, with `illegal` = 1.
  - MEMADR: to MEMREAD for loads, MEMWRITE for stores.
  - MEMREAD → MEMWB when `mem_ready`.
  - MEMWRITE → FETCH when `mem_ready`.
  - EXECR, EXECI and JAL → ALUWB.
  - MEMWB, ALUWB and BEQ → FETCH.
- Outputs per state (anything unlisted is 0):
  - FETCH: `mem_req`, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. `IRWrite` and `PCUpdate` are asserted only in the cycle `mem_ready`=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: `mem_req`, AdrSrc=1, ResultSrc=00.
  - MEMWRITE: `mem_req`, `MemWrite`, AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, `RegWrite`, `retire`.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, `RegWrite`, `retire`.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, `Branch`, `retire`.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, `PCUpdate`. ALUWB follows and writes the link value (OldPC+4).
  - MEMWRITE: `retire` pulses in the cycle `mem_ready`=1.
- Handshake:
  - `mem_req`, `MemWrite` and `AdrSrc` stay stable for the whole wait; the FSM holds its state until `mem_ready`.
  - `mem_ready` sampled while `mem_req`=0 is ignored.
- `opcode` is sampled only in DECODE and MEMADR; the IR does not change outside the FETCH completion cycle.

## Timing
- State register updates on the rising edge of `clk`; all outputs are Moore-decoded from state, except the FETCH `IRWrite`/`PCUpdate` and the MEMWRITE `retire`, which are gated by `mem_ready`.
- Cycles per instruction with zero-wait memory (`mem_ready` high in the request cycle):
  - load: 5
  - store: 4
  - R-type or I-type ALU: 4
  - beq: 3
  - jal: 4
  - illegal: 2
- Each wait cycle adds exactly 1 cycle to FETCH, MEMREAD or MEMWRITE.
- While `reset`=1:
  - state ← FETCH.
  - All outputs are forced to 0, including `mem_req`, and `state_dbg` reads FETCH.
  - First `mem_req` = 1 in the cycle after `reset` falls.
- Reset asserted during a memory wait: the request is abandoned and `mem_req` drops in the same cycle. A `mem_ready` arriving in that cycle is ignored, and no `IRWrite`, `RegWrite` or `retire` occurs.
- `illegal` and `retire` are never high in the same cycle.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - opcode constants (R, I-ALU, LOAD, STORE, BRANCH, JAL);
  - state enum, 4-bit encoding, FETCH = 0;
  - ALUSrcA, ALUSrcB, ResultSrc and ALUOp encodings, shared with the datapath muxes.
- No sub-module: one state register, a next-state block and an output decode block. ALUOp feeds the existing downstream ALU decoder unchanged.

## Test plan
- Reset held 3 cycles, then released:
  - all outputs 0 during reset;
  - cycle 1 after release: `state_dbg`=0 and `mem_req`=1.
- R-type (opcode 0110011), zero-wait: states FETCH, DECODE, EXECR, ALUWB. `RegWrite` = 1 only in ALUWB with ResultSrc=00; one `retire`; 4 cycles total.
- Load (0000011) with 2 wait cycles on fetch and 1 on read:
  - `mem_req` held 3 cycles then 2 cycles;
  - `IRWrite` only in the ready cycle;
  - MEMWB asserts ResultSrc=01 and `RegWrite`;
  - 8 cycles total.
- Store (0100011), then beq (1100011):
  - store: `MemWrite` = 1 only in MEMWRITE, `retire` in its ready cycle;
  - beq: `Branch` = 1 with ALUOp=01 in state 3 of the instruction, returning to FETCH.
- Illegal opcode 0000000: `illegal` pulses for exactly 1 cycle in DECODE; next state FETCH; no `RegWrite` and no `retire`.
- `reset` raised during a MEMREAD wait, with `mem_ready` = 1 in the same cycle: `mem_req` = 0 immediately, no `RegWrite`, state FETCH after the edge.
